neuron_mac: RTL and testbench

- Upstream stage of the tanh CORDIC unit in the MLP datapath.
- Computes one neuron pre-activation, sum(x_i*w_i) + bias, over N_INPUTS serially presented activation/weight pairs.
- Saturates the result to signed Q8.8 (16 bits). This matches the CORDIC input format, so sum_out connects directly to the CORDIC `in` port.
- Activations x are the 8-bit signed Q1.7 outputs of the previous layer's tanh units.

---
 rtl/neuron_mac.sv | 107 ++++++++++
 tb/tb_neuron_mac.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate for one neuron: sum(x_i*w_i) + bias, saturated to Q8.8.
// Feeds the tanh CORDIC stage directly; x is Q1.7, w and bias are Q8.8.
module neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  x_in,
  input  logic [15:0] w_in,
  input  logic [15:0] bias,
  output logic        busy,
  output logic [15:0] sum_out,
  output logic        out_valid
);

  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, BIAS = 2'd2, OUT = 2'd3} state_t;

  state_t                    state_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic        [CW-1:0]      count_r;
  logic                      busy_r;
  logic        [15:0]        sum_r;
  logic                      out_valid_r;

  logic signed [23:0]        prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   bias_ext_s;
  logic signed [ACC_W-1:0]   shifted_s;
  logic        [15:0]        sat_s;

  assign prod_s     = $signed(x_in) * $signed(w_in);
  assign prod_ext_s = {{(ACC_W-24){prod_s[23]}}, prod_s};
  // Bias is Q8.8; shifting left by 7 aligns it with the Q9.15 products.
  assign bias_ext_s = {{(ACC_W-23){bias[15]}}, bias, 7'b0000000};
  assign shifted_s  = acc_r >>> 7;

  // Saturate the Q8.8 view of the accumulator: out of range when the bits above 15 disagree with the sign.
  always_comb begin
    sat_s = shifted_s[15:0];
    if (!shifted_s[ACC_W-1] && (|shifted_s[ACC_W-2:15])) begin
      sat_s = 16'h7FFF;
    end else if (shifted_s[ACC_W-1] && !(&shifted_s[ACC_W-2:15])) begin
      sat_s = 16'h8000;
    end else begin
      sat_s = shifted_s[15:0];
    end
  end

  // Control FSM with accumulator, pair counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      count_r     <= '0;
      busy_r      <= 1'b0;
      sum_r       <= 16'h0000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= '0;
            count_r <= '0;
            busy_r  <= 1'b1;
            state_r <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_r <= acc_r + prod_ext_s;
            if (count_r == CW'(N_INPUTS - 1)) begin
              count_r <= '0;
              state_r <= BIAS;
            end else begin
              count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        BIAS: begin
          acc_r   <= acc_r + bias_ext_s;
          state_r <= OUT;
        end
        OUT: begin
          sum_r       <= sat_s;
          out_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign sum_out   = sum_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac with N_INPUTS=4.
module tb_neuron_mac;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  x_in;
  logic [15:0] w_in;
  logic [15:0] bias;
  logic        busy;
  logic [15:0] sum_out;
  logic        out_valid;

  int tests_run;
  int tests_failed;

  neuron_mac #(.N_INPUTS(4), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .x_in(x_in), .w_in(w_in), .bias(bias),
    .busy(busy), .sum_out(sum_out), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic start_eval();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one pair after `gap` idle cycles; reports whether busy dropped during the gap.
  task automatic feed(input logic [7:0] x, input logic [15:0] w, input int gap, output logic busy_low);
    busy_low = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (busy !== 1'b1) busy_low = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b1;
    x_in = x;
    w_in = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges from the last accepted pair until out_valid; lat=-1 on timeout.
  task automatic wait_result(output int lat, output logic [15:0] s, output logic ov_after);
    lat = -1;
    s = 16'hxxxx;
    ov_after = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        s = sum_out;
        break;
      end
    end
    @(negedge clk);
    ov_after = out_valid;
  endtask

  task automatic run_four(input logic [7:0] x, input logic [15:0] w, output int lat,
                          output logic [15:0] s, output logic ov_after);
    logic bl;
    start_eval();
    for (int i = 0; i < 4; i++) feed(x, w, 0, bl);
    wait_result(lat, s, ov_after);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b out_valid=%b sum_out=%h, want 0/0/0000", busy, out_valid, sum_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    int lat; logic [15:0] s; logic ova;
    bias = 16'h0080;
    run_four(8'h40, 16'h0100, lat, s, ova);
    tests_run++;
    if (s !== 16'h0280) begin
      tests_failed++;
      $display("FAIL nominal_sum: got %h want 0280", s);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL nominal_latency: got %0d want 3", lat);
    end
    tests_run++;
    if (ova !== 1'b0) begin
      tests_failed++;
      $display("FAIL nominal_pulse_width: out_valid after pulse %b want 0", ova);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL nominal_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_gapped();
    int lat; logic [15:0] s; logic ova; logic bl; logic any_low;
    bias = 16'h0080;
    any_low = 1'b0;
    start_eval();
    for (int i = 0; i < 4; i++) begin
      feed(8'h40, 16'h0100, i + 1, bl);
      any_low = any_low | bl;
    end
    wait_result(lat, s, ova);
    tests_run++;
    if (s !== 16'h0280) begin
      tests_failed++;
      $display("FAIL gapped_sum: got %h want 0280", s);
    end
    tests_run++;
    if (any_low !== 1'b0) begin
      tests_failed++;
      $display("FAIL gapped_busy: busy dropped=%b want 0", any_low);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL gapped_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] s; logic ova;
    bias = 16'h0000;
    run_four(8'h7F, 16'h7FFF, lat, s, ova);
    tests_run++;
    if (s !== 16'h7FFF) begin
      tests_failed++;
      $display("FAIL sat_pos: got %h want 7fff", s);
    end
    run_four(8'h80, 16'h7FFF, lat, s, ova);
    tests_run++;
    if (s !== 16'h8000) begin
      tests_failed++;
      $display("FAIL sat_neg: got %h want 8000", s);
    end
  endtask

  task automatic test_neg_trunc();
    int lat; logic [15:0] s; logic ova;
    bias = 16'h0000;
    run_four(8'hFF, 16'h0001, lat, s, ova);
    tests_run++;
    if (s !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL neg_trunc: got %h want ffff", s);
    end
  endtask

  task automatic test_protocol();
    int lat; logic [15:0] s; logic ova; logic bl; logic idle_ov;
    bias = 16'h0080;
    idle_ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x_in = 8'h7F; w_in = 16'h7FFF;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid !== 1'b0 || busy !== 1'b0) idle_ov = 1'b1;
    end
    tests_run++;
    if (idle_ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_in_valid: activity seen=%b want 0", idle_ov);
    end
    start_eval();
    feed(8'h40, 16'h0100, 0, bl);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; x_in = 8'h40; w_in = 16'h0100;
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    feed(8'h40, 16'h0100, 0, bl);
    feed(8'h40, 16'h0100, 0, bl);
    wait_result(lat, s, ova);
    tests_run++;
    if (s !== 16'h0280 || lat !== 3) begin
      tests_failed++;
      $display("FAIL start_in_acc: got %h lat %0d want 0280 lat 3", s, lat);
    end
  endtask

  task automatic test_start_drop();
    int lat; logic [15:0] s; logic ova; logic bl;
    bias = 16'h0080;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; x_in = 8'h7F; w_in = 16'h7FFF;
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) feed(8'h40, 16'h0100, 0, bl);
    wait_result(lat, s, ova);
    tests_run++;
    if (s !== 16'h0280 || lat !== 3) begin
      tests_failed++;
      $display("FAIL start_pair_drop: got %h lat %0d want 0280 lat 3", s, lat);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [15:0] s; logic ova; logic bl; logic spur;
    bias = 16'h0080;
    start_eval();
    feed(8'h40, 16'h0100, 0, bl);
    feed(8'h40, 16'h0100, 0, bl);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (sum_out !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midrun: sum_out=%h out_valid=%b busy=%b want 0000/0/0", sum_out, out_valid, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) spur = 1'b1;
    end
    tests_run++;
    if (spur !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: activity after reset=%b want 0", spur);
    end
    run_four(8'h40, 16'h0100, lat, s, ova);
    tests_run++;
    if (s !== 16'h0280 || lat !== 3) begin
      tests_failed++;
      $display("FAIL after_reset_run: got %h lat %0d want 0280 lat 3", s, lat);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    x_in = 8'h00; w_in = 16'h0000; bias = 16'h0000;
    test_reset();
    test_nominal();
    test_gapped();
    test_saturation();
    test_neg_trunc();
    test_protocol();
    test_start_drop();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
